// File: rtl/port_pkg.sv
// Shared widths and the transmitter state encoding for the port_tx slice.
package port_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/port_tx_baud.sv
// Baud divider: counts clk cycles within one serial bit, ticks on the last one.
// Latency: bit_tick is combinational from the count register.
// Backpressure: none; restart holds the count at zero.
module port_tx_baud #(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic restart,
    output logic bit_tick
);

    localparam logic [7:0] LAST = 8'(BAUD_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || cnt_q == LAST) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = !restart && (cnt_q == LAST);

endmodule

// File: rtl/port_tx.sv
// Serial transmitter for one of NUM_PORTS byte sources; optional parity via PORT_TX_PARITY_EN.
// Latency: 10*BAUD_DIV cycles load-to-idle (11*BAUD_DIV with parity); tx_serial low the cycle after load.
// Backpressure: data_empty=0 means busy; wr_data while busy is dropped and sets sticky overrun.
module port_tx
    import port_pkg::*;
#(
    parameter int BAUD_DIV = 4
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        wr_data,
    input  logic [PORT_W-1:0]           select,
    input  logic [NUM_PORTS*DATA_W-1:0] port_data,
    input  logic                        ovr_clr,
    output logic                        data_empty,
    output logic                        tx_serial,
    output logic [PORT_W-1:0]           tx_port,
    output logic                        frame_done,
    output logic                        overrun
);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              tx_serial_q, tx_serial_d;
    logic              data_empty_q, data_empty_d;
    logic [PORT_W-1:0] tx_port_q, tx_port_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
`ifdef PORT_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              bit_tick;
    logic              baud_restart;
    logic [DATA_W-1:0] sel_byte;

    // Counter sits at zero while idle so the start bit gets a full period.
    assign baud_restart = (state_q == ST_IDLE);

    port_tx_baud #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .rst_b   (rst_b),
        .restart (baud_restart),
        .bit_tick(bit_tick)
    );

    assign sel_byte = port_data[int'(select)*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        tx_serial_d  = tx_serial_q;
        data_empty_d = data_empty_q;
        tx_port_d    = tx_port_q;
        frame_done_d = 1'b0;
`ifdef PORT_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        // Set wins over clear when both land in the same cycle.
        if (wr_data && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_data) begin
                    shift_d      = sel_byte;
                    tx_port_d    = select;
                    bit_cnt_d    = 3'd0;
                    tx_serial_d  = 1'b0;
                    data_empty_d = 1'b0;
                    state_d      = ST_START;
`ifdef PORT_TX_PARITY_EN
                    parity_d     = even_parity(sel_byte);
`endif
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    tx_serial_d = shift_q[0];
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef PORT_TX_PARITY_EN
                        tx_serial_d = parity_q;
                        state_d     = ST_PARITY;
`else
                        tx_serial_d = 1'b1;
                        state_d     = ST_STOP;
`endif
                    end else begin
                        tx_serial_d = shift_q[1];
                    end
                end
            end
`ifdef PORT_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    tx_serial_d = 1'b1;
                    state_d     = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    tx_serial_d  = 1'b1;
                    data_empty_d = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                tx_serial_d  = 1'b1;
                data_empty_d = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= 3'd0;
            tx_serial_q  <= 1'b1;
            data_empty_q <= 1'b1;
            tx_port_q    <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PORT_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_serial_q  <= tx_serial_d;
            data_empty_q <= data_empty_d;
            tx_port_q    <= tx_port_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
`ifdef PORT_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign data_empty = data_empty_q;
    assign tx_serial  = tx_serial_q;
    assign tx_port    = tx_port_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_port_tx.sv
// Bench for port_tx: directed frames plus random byte/port streams against a bit-list model.
module tb_port_tx;

    localparam int BD = 4;
`ifdef PORT_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk;
    logic        rst_b;
    logic        wr_data;
    logic [1:0]  select;
    logic [31:0] port_data;
    logic        ovr_clr;
    logic        data_empty;
    logic        tx_serial;
    logic [1:0]  tx_port;
    logic        frame_done;
    logic        overrun;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic ovr_exp;

    port_tx #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .wr_data   (wr_data),
        .select    (select),
        .port_data (port_data),
        .ovr_clr   (ovr_clr),
        .data_empty(data_empty),
        .tx_serial (tx_serial),
        .tx_port   (tx_port),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of frame bit k: start, 8 data LSB first, optional even parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NBITS == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic load(input logic [7:0] b, input logic [1:0] sel);
        port_data = $urandom;
        port_data[int'(sel)*8 +: 8] = b;
        select  = sel;
        wr_data = 1'b1;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle data_empty", 32'(data_empty), 32'd1);
        chk("idle frame_done", 32'(frame_done), 32'd0);
        chk("idle tx_serial", 32'(tx_serial), 32'd1);
        chk("idle overrun", 32'(overrun), 32'(ovr_exp));
    endtask

    // Expects a load already driven; checks every cycle of the frame.
    task automatic run(input logic [7:0] b, input logic [1:0] sel, input bit ovr_test,
                       input int stop_at, input bit chain,
                       input logic [7:0] nb, input logic [1:0] nsel);
        int n;
        bit wr_now;
        bit clr_now;
        n = NBITS * BD;
        @(negedge clk);
        wr_data   = 1'b0;
        port_data = $urandom;
        select    = 2'($urandom);
        for (int i = 0; i <= n; i++) begin
            if (i == stop_at) return;
            if (i < n) begin
                chk("tx_serial", 32'(tx_serial), 32'(exp_bit(b, i / BD)));
                chk("busy data_empty", 32'(data_empty), 32'd0);
                chk("busy frame_done", 32'(frame_done), 32'd0);
            end else begin
                chk("end data_empty", 32'(data_empty), 32'd1);
                chk("end frame_done", 32'(frame_done), 32'd1);
                chk("end tx_serial", 32'(tx_serial), 32'd1);
            end
            chk("tx_port", 32'(tx_port), 32'(sel));
            chk("overrun", 32'(overrun), 32'(ovr_exp));
            port_data = $urandom;
            if (i < n) begin
                wr_now  = ovr_test && (i == 5 || i == 15);
                clr_now = ovr_test && (i == 10 || i == 15);
                wr_data = wr_now;
                ovr_clr = clr_now;
                if (wr_now) select = 2'($urandom);
                if (wr_now) ovr_exp = 1'b1;
                else if (clr_now) ovr_exp = 1'b0;
                @(negedge clk);
            end else begin
                wr_data = 1'b0;
                ovr_clr = 1'b0;
                if (chain) load(nb, nsel);
            end
        end
    endtask

    initial begin
        logic [7:0] cb, nb;
        logic [1:0] cs, ns;
        bit         ch;

        rst_b = 1'b0; wr_data = 1'b0; select = 2'd0; port_data = 32'd0; ovr_clr = 1'b0;
        ovr_exp = 1'b0;
        #12;
        chk("rst data_empty", 32'(data_empty), 32'd1);
        chk("rst tx_serial", 32'(tx_serial), 32'd1);
        chk("rst tx_port", 32'(tx_port), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);

        // Load on the first edge after release.
        @(negedge clk);
        rst_b = 1'b1;
        load(8'hA5, 2'd2);
        run(8'hA5, 2'd2, 1'b0, -1, 1'b0, 8'h00, 2'd0);
        idle_chk();

        load(8'h01, 2'd1);
        run(8'h01, 2'd1, 1'b0, -1, 1'b0, 8'h00, 2'd0);
        idle_chk();

        // Overrun set, clear, and simultaneous set/clear inside one frame.
        load(8'h3C, 2'd0);
        run(8'h3C, 2'd0, 1'b1, -1, 1'b0, 8'h00, 2'd0);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        ovr_exp = 1'b0;
        chk("overrun cleared", 32'(overrun), 32'd0);

        // Back-to-back: load on the frame_done cycle.
        load(8'h5A, 2'd1);
        run(8'h5A, 2'd1, 1'b0, -1, 1'b1, 8'hFF, 2'd3);
        run(8'hFF, 2'd3, 1'b0, -1, 1'b0, 8'h00, 2'd0);
        idle_chk();

        cb = 8'($urandom);
        cs = 2'($urandom);
        load(cb, cs);
        for (int k = 0; k < 10; k++) begin
            nb = 8'($urandom);
            ns = 2'($urandom);
            ch = (k < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            run(cb, cs, 1'b0, -1, ch, nb, ns);
            if (!ch && k < 9) begin
                idle_chk();
                load(nb, ns);
            end
            cb = nb;
            cs = ns;
        end
        idle_chk();

        // Reset during data bit 4.
        load(8'hC3, 2'd2);
        run(8'hC3, 2'd2, 1'b0, BD*5 + 1, 1'b0, 8'h00, 2'd0);
        rst_b = 1'b0;
        #1;
        chk("mid rst tx_serial", 32'(tx_serial), 32'd1);
        chk("mid rst data_empty", 32'(data_empty), 32'd1);
        chk("mid rst tx_port", 32'(tx_port), 32'd0);
        chk("mid rst frame_done", 32'(frame_done), 32'd0);
        ovr_exp = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        for (int j = 0; j < 3 * BD; j++) idle_chk();
        load(8'h96, 2'd1);
        run(8'h96, 2'd1, 1'b0, -1, 1'b0, 8'h00, 2'd0);
        idle_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/port_tx.md
PORT_TX -- requirements
Module: port_tx

Interface
REQ-001 Parameter BAUD_DIV, default 4, clk cycles per serial bit; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 wr_data  input  1  one-cycle load strobe from the upstream port queue; load the port named by select.
REQ-005 select  input  2  index of the port whose byte is loaded on wr_data.
REQ-006 port_data  input  4x8  packed per-port data bytes, port N at bits [8N+7:8N].
REQ-007 ovr_clr  input  1  synchronous clear of the overrun flag.
REQ-008 data_empty  output  1  registered; 1 = transmitter idle and able to accept wr_data.
REQ-009 tx_serial  output  1  registered serial line, idle high.
REQ-010 tx_port  output  2  registered; select value latched for the frame in progress.
REQ-011 frame_done  output  1  registered one-cycle pulse on the cycle data_empty returns to 1.
REQ-012 overrun  output  1  sticky; set when wr_data arrives while data_empty=0.

Function
REQ-013 States IDLE, START, DATA, PARITY, STOP; IDLE is the only state with data_empty=1.
REQ-014 IDLE with wr_data=1 at posedge: latch port_data[select] into shift register, select into tx_port, go to START; next cycle data_empty=0 and tx_serial=0.
REQ-015 Each bit state holds tx_serial constant for exactly BAUD_DIV cycles, timed by the baud counter, which restarts at 0 on every bit boundary.
REQ-016 START -> DATA; DATA sends 8 bits LSB first, using a 3-bit bit counter; after bit 7 go to PARITY (if enabled) or STOP.
REQ-017 PARITY drives even parity of the latched byte (XOR of all 8 bits); then STOP.
REQ-018 STOP drives 1 for BAUD_DIV cycles, then IDLE; on that transition data_empty=1 and frame_done=1 for one cycle.
REQ-019 Frame latency wr_data to data_empty high: 10*BAUD_DIV cycles (11*BAUD_DIV with parity).
REQ-020 wr_data in the same cycle data_empty reads 1 is accepted; back-to-back frames produce no idle bit between STOP and next START.
REQ-021 wr_data while data_empty=0: ignored for data, tx_port unchanged, overrun set to 1 next cycle.
REQ-022 ovr_clr and a new overrun in the same cycle: overrun remains 1 (set wins).
REQ-023 port_data changes after load have no effect on the frame in progress.
REQ-024 select is sampled only on an accepted wr_data; other values of select are don't-care.

Reset
REQ-025 rst_b low forces, asynchronously: state IDLE, data_empty=1, tx_serial=1, tx_port=0, frame_done=0, overrun=0, counters and shift register 0.
REQ-026 Reset mid-frame aborts the frame; no partial stop bit or frame_done is produced after release.
REQ-027 First wr_data is accepted on the first posedge after rst_b deasserts.

Configuration
REQ-028 Macro PORT_TX_PARITY_EN: defined -> PARITY state present, 11-bit frame; undefined -> PARITY state absent, DATA goes directly to STOP, 10-bit frame.

Structure
REQ-029 Shared package port_pkg holds NUM_PORTS=4, PORT_W=2, DATA_W=8, and the tx_state_t enum.
REQ-030 Sub-module port_tx_baud (baud counter, emits bit_tick on the last cycle of each bit period, restart input) is instantiated once.
REQ-031 Expected size 120-400 lines of RTL including the sub-module.

Verification
REQ-032 BAUD_DIV=4, parity on: select=2, port_data[2]=8'hA5, wr_data pulse -> tx_serial 0,1,0,1,0,0,1,0,1,0(par),1, each bit held 4 cycles; data_empty low 44 cycles; frame_done once; tx_port=2.
REQ-033 Parity off, port_data[1]=8'h01, select=1 -> frame 0,1,0,0,0,0,0,0,0,1; data_empty low 40 cycles.
REQ-034 Second wr_data 5 cycles into a frame -> frame unchanged, overrun=1 until ovr_clr pulse, then 0.
REQ-035 wr_data held on the cycle frame_done=1, select=3, port_data[3]=8'hFF -> START immediately follows STOP, no idle gap, tx_port=3.
REQ-036 rst_b low for 1 cycle during DATA bit 4 -> tx_serial=1 and data_empty=1 immediately; no frame_done; next wr_data sends a clean full frame.
